// File: rtl/muldiv_pkg.sv
// Shared types and constants for the muldiv request arbiter.
package muldiv_pkg;

    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    function automatic logic is_div(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/muldiv_arbiter_rr_arb2.sv
// Two-way round-robin grant; the tie-break pointer moves only when a grant is taken.
module rr_arb2
    import muldiv_pkg::*;
(
    input  logic            i_clk_n,
    input  logic            i_rst,
    input  logic [NREQ-1:0] i_valid,
    input  logic            i_idle,
    input  logic            i_md_busy,
    output logic [NREQ-1:0] o_grant,
    output logic            o_id,
    output logic            o_accept
);

    // 1 when req1 wins a tie
    logic prio_q;

    always_comb begin
        o_grant = '0;
        if (i_idle && !i_md_busy) begin
            if (&i_valid)
                o_grant = prio_q ? 2'b10 : 2'b01;
            else
                o_grant = i_valid;
        end
    end

    assign o_accept = |o_grant;
    assign o_id     = o_grant[1];

    always_ff @(posedge i_clk_n or posedge i_rst) begin
        if (i_rst)
            prio_q <= 1'b0;
        else if (o_accept)
            prio_q <= ~o_id;
    end

endmodule

// File: rtl/muldiv_arbiter.sv
// Shares one iterative muldiv between two requesters: accept, issue one enable pulse,
// wait for busy to fall, then return the registered result with the requester's tag.
module muldiv_arbiter
    import muldiv_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                 i_clk_n,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [63:0]          i_req_a,
    input  logic [63:0]          i_req_b,
    input  logic [5:0]           i_req_funct3,
    input  logic [2*TAG_W-1:0]   i_req_tag,
    output logic [NREQ-1:0]      o_rsp_valid,
    input  logic [NREQ-1:0]      i_rsp_ready,
    output logic [31:0]          o_rsp_data,
    output logic [TAG_W-1:0]     o_rsp_tag,
    output logic [31:0]          o_md_a,
    output logic [31:0]          o_md_b,
    output logic [2:0]           o_md_funct3,
    output logic                 o_md_en,
    input  logic [31:0]          i_md_result,
    input  logic                 i_md_busy,
    output logic                 o_busy,
    output logic [CNT_W-1:0]     o_ops_done
);

    state_t           state, state_nxt;
    logic [NREQ-1:0]  grant;
    logic             gid;
    logic             accept;
    logic             id_q;
    logic             rsp_fire;
    logic             capture;

    rr_arb2 u_arb (
        .i_clk_n   (i_clk_n),
        .i_rst     (i_rst),
        .i_valid   (i_req_valid),
        .i_idle    (state == ST_IDLE),
        .i_md_busy (i_md_busy),
        .o_grant   (grant),
        .o_id      (gid),
        .o_accept  (accept)
    );

    assign o_req_ready = grant;
    assign rsp_fire    = (state == ST_RESP) && i_rsp_ready[id_q];
    assign capture     = (state == ST_WAIT) && !i_md_busy;

    always_ff @(posedge i_clk_n or posedge i_rst) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        o_md_en     = 1'b0;
        o_rsp_valid = '0;
        o_busy      = (state != ST_IDLE);
        unique case (state)
            ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                o_md_en   = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT:  if (!i_md_busy) state_nxt = ST_RESP;
            ST_RESP: begin
                o_rsp_valid[id_q] = 1'b1;
                if (rsp_fire) state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Operands stay latched after accept; muldiv post-processing reads them live.
    always_ff @(posedge i_clk_n or posedge i_rst) begin
        if (i_rst) begin
            o_md_a      <= '0;
            o_md_b      <= '0;
            o_md_funct3 <= '0;
            o_rsp_tag   <= '0;
            id_q        <= 1'b0;
        end else if (accept) begin
            o_md_a      <= gid ? i_req_a[63:32]            : i_req_a[31:0];
            o_md_b      <= gid ? i_req_b[63:32]            : i_req_b[31:0];
            o_md_funct3 <= gid ? i_req_funct3[5:3]         : i_req_funct3[2:0];
            o_rsp_tag   <= gid ? i_req_tag[2*TAG_W-1:TAG_W] : i_req_tag[TAG_W-1:0];
            id_q        <= gid;
        end
    end

    always_ff @(posedge i_clk_n or posedge i_rst) begin
        if (i_rst) begin
            o_rsp_data <= '0;
            o_ops_done <= '0;
        end else begin
            if (capture)
                o_rsp_data <= i_md_result;
            if (rsp_fire)
                o_ops_done <= o_ops_done + CNT_W'(1);
        end
    end

endmodule

// File: doc/muldiv_arbiter.md
Name: muldiv_arbiter

Overview:
- Shares one iterative muldiv unit between two requesters: req0 is the CPU execute stage, req1 is the coprocessor/debug port.
- Accepts operations on a valid/ready request channel and arbitrates round-robin.
- Drives the muldiv operand and control inputs, holding them stable for the whole operation, and pulses its enable for exactly one cycle.
- Waits on the muldiv busy signal, registers the result and returns it with the requester's tag on a valid/ready response channel.

Parameters:
TAG_W, 4, width of the per-request tag echoed on the response.
CNT_W, 16, width of the completed-operation counter.

Ports:
i_clk_n  in  1  clock; all flops update on its rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_req_valid  in  2  bit i = requester i has an operation.
o_req_ready  out  2  bit i = operation from requester i accepted this edge.
i_req_a  in  64  operand A; [31:0] is req0, [63:32] is req1.
i_req_b  in  64  operand B, same packing.
i_req_funct3  in  6  RV32M funct3; [2:0] is req0, [5:3] is req1.
i_req_tag  in  2*TAG_W  tags, same packing.
o_rsp_valid  out  2  one-hot; result is ready for requester i.
i_rsp_ready  in  2  requester i consumes the response.
o_rsp_data  out  32  registered result.
o_rsp_tag  out  TAG_W  tag of the completed operation.
o_md_a  out  32  to muldiv i_in_a.
o_md_b  out  32  to muldiv i_in_b.
o_md_funct3  out  3  to muldiv i_funct3.
o_md_en  out  1  drives muldiv i_alu_en and i_funct7_0; muldiv i_alu_imm is tied 0.
i_md_result  in  32  from muldiv o_result.
i_md_busy  in  1  from muldiv o_busy.
o_busy  out  1  state is not IDLE.
o_ops_done  out  CNT_W  count of completed responses.

Behaviour:
- Reset values: all outputs 0; state IDLE; the round-robin pointer favours req0.
- States:
  - IDLE: o_req_ready is granted to one requester only when i_md_busy=0. The muldiv has no reset, so after a mid-operation reset the arbiter waits for busy to fall before issuing.
  - Request acceptance: o_req_ready[i] is combinational. When valid&ready at an edge, the arbiter latches a, b, funct3, tag and the requester id, then goes to ISSUE.
  - ISSUE (exactly 1 cycle): o_md_en=1 with the latched operands on o_md_*. Then go to WAIT.
  - WAIT: o_md_en=0 and operands are held. On the first cycle with i_md_busy=0, capture i_md_result into o_rsp_data at the edge and go to RESP.
  - RESP: o_rsp_valid[id]=1 with data and tag stable until i_rsp_ready[id]=1 at an edge. On that edge o_ops_done increments and the state returns to IDLE.
- Operand hold: o_md_a, o_md_b and o_md_funct3 stay stable from ISSUE through the capture edge. The muldiv post-processing (sign, high/low select) reads them combinationally.
- o_md_en must never be high outside ISSUE. The divider reloads on every enabled cycle; the multiplier restarts if enable is held after completion.
- Latency, counting edge E0 as the accept edge:
  - Fast multiplier: capture at E2, o_rsp_valid high after E2.
  - Iterative multiplier with B=0: capture at E2, result 0.
  - Iterative multiplier, general: capture one edge after the multiplier's B register clears.
  - Divider: busy for 32 cycles after E1, capture at E34, o_rsp_valid high after E34.
- Arbitration:
  - If both requesters are valid, grant the one not granted last.
  - If one is valid, grant it regardless of the pointer.
  - The pointer updates only on accept.
  - At most one accept per edge; no new accept before RESP completes (single outstanding op).
  - i_req_valid dropped before accept is legal and is ignored.
- i_rsp_ready of the non-addressed requester is ignored.
- o_ops_done wraps modulo 2^CNT_W.
- Reset mid-operation: state → IDLE, latched op discarded, no response.
- funct3 passes through unchanged; all 8 values are legal. Divide-by-zero and overflow return whatever the muldiv produces.

Decomposition:
- Package muldiv_pkg:
  - state encoding (IDLE/ISSUE/WAIT/RESP, 2 bits);
  - NREQ=2;
  - funct3 localparams MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU;
  - helper is_div = funct3[2].
- Sub-module rr_arb2: 2-way round-robin grant from valid, pointer and !busy, with update on accept.

Test Plan:
- req0 MUL a=7 b=6 funct3=000 tag=3, rsp_ready held 1 -> o_md_en high exactly 1 cycle; o_rsp_valid=01 with data=42, tag=3; o_ops_done=1.
- req1 DIVU a=100 b=7 funct3=101 -> capture at E34, o_rsp_valid=10, data=14; REMU in the same setup -> data=2; o_md_a/b/funct3 are stable for every cycle of WAIT.
- Both requesters valid every cycle, req0 MUL 3*3, req1 MUL 5*5, each response acked immediately -> accept order req0, req1, req0, req1; data 9, 25, 9, 25; exactly one bit of o_req_ready high per accept.
- req0 DIV a=-20 b=3 with i_rsp_ready low for 10 cycles after valid -> data=0xFFFFFFFA held stable; no new accept while req1 is valid; accept resumes after the ack.
- Assert i_rst 10 cycles into a DIVU, then offer a new req0 -> all outputs 0; o_req_ready stays 0 until i_md_busy falls; new op result is correct.
- Iterative MUL b=0 and MULHU 0xFFFFFFFF*0xFFFFFFFF -> data=0 with capture at E2; data=0xFFFFFFFE.
